ysyx_23060208_ifu: RTL and testbench
====================================

# ysyx_23060208_ifu

Instruction fetch unit for the multi-cycle NPC core: owns the PC and fetches one instruction at a time over an AXI4-Lite read port. It delivers `{pc, inst}` to the IDU over the valid/allowin handshake. It then waits for the EXU to return the next PC before starting the next fetch, so no speculative fetch is ever issued. The block is the transmitting end of the IFU→IDU bus and the source of every PC the core executes.

## Interface
Parameters:
- `DATA_WIDTH`, 32, address/instruction width
- `RESET_PC`, 32'h8000_0000, first fetch address after reset

Ports:
- `clock`  in  1  core clock; all state on rising edge
- `reset`  in  1  asynchronous, active-low reset (asserted when 0)
- `araddr`  out  DATA_WIDTH  fetch address; equals current PC
- `arvalid`  out  1  read address valid
- `arready`  in  1  read address ready
- `rdata`  in  DATA_WIDTH  instruction word
- `rresp`  in  2  read response; 2'b00 = OKAY
- `rvalid`  in  1  read data valid
- `rready`  out  1  read data ready
- `ifu_to_idu_bus`  out  2*DATA_WIDTH  `{pc, inst}`; pc in upper half
- `ifu_to_idu_valid`  out  1  bus holds an undelivered instruction
- `idu_allowin`  in  1  IDU accepts this cycle
- `exu_nextpc`  in  DATA_WIDTH  PC of next instruction
- `exu_nextpc_valid`  in  1  one-cycle strobe qualifying `exu_nextpc`
- `fetch_err`  out  1  sticky; a fetch returned non-OKAY `rresp`
- `perf_fetch_cnt`  out  32  delivered instructions
- `perf_stall_cnt`  out  32  cycles spent waiting on the bus

## Operation
- Five states: BOOT, AR, R, SEND, WAIT_PC. Reset state is BOOT.
- BOOT: all handshake outputs low. Next cycle moves to AR unconditionally.
- AR: `arvalid`=1 and `araddr`=pc_r; both stay stable until `arready`. On `arvalid && arready`, move to R.
- R: `rready`=1. On `rvalid`:
  - latch `inst_r <= rdata`;
  - if `rresp != 0`, set `fetch_err` (sticky until reset);
  - move to SEND.
  - The instruction is delivered even on error.
- SEND: `ifu_to_idu_valid`=1. `ifu_to_idu_bus` = `{pc_r, inst_r}` and stays stable while valid. On `idu_allowin`, move to WAIT_PC.
- WAIT_PC: all outputs idle. On `exu_nextpc_valid`, set `pc_r <= exu_nextpc` and move to AR.
- `exu_nextpc_valid` seen in any other state is ignored. The EXU guarantees it is never sent before the matching instruction has been accepted.
- No alignment checks; `araddr` is passed through as-is.
- Reset values:
  - pc_r = RESET_PC; inst_r = 0; state = BOOT.
  - `arvalid`, `rready`, `ifu_to_idu_valid` and `fetch_err` = 0.
  - Both perf counters = 0.
- Reset asserted mid-transaction (any state): return to BOOT immediately and drop `arvalid`/`rready` asynchronously. Outstanding AXI beats are not tracked; the interconnect is reset together with the core.

## Timing
- All outputs are registered or decoded purely from state; there are no input→output combinational paths.
- Minimum fetch timing, with `arready` and `rvalid` each high at first opportunity:
  - AR handshake in cycle T;
  - `rvalid` sampled in T+1;
  - `ifu_to_idu_valid` high in T+2.
- Back-to-back instructions, minimum spacing, with `idu_allowin`=1 and nextpc returned one cycle after acceptance:
  - accept in cycle S;
  - WAIT_PC in S+1 with nextpc strobe;
  - AR in S+2.
  - This gives 4 cycles per instruction.
- `arvalid` is never withdrawn before `arready`, and `ifu_to_idu_valid` is never withdrawn before `idu_allowin` (AXI/handshake rule).
- Counters wrap modulo 2^32.

## Configuration
- Macro `YSYX_23060208_IFU_PERF_EN`.
- Defined:
  - `perf_fetch_cnt` increments on each `ifu_to_idu_valid && idu_allowin`;
  - `perf_stall_cnt` increments every cycle the state is AR or R.
- Undefined: both counter registers are omitted; the ports are tied to 0.

## Test plan
- Reset release, memory always ready, returning 32'h0000_0013 → `araddr`=8000_0000 in first AR cycle; valid 2 cycles after AR handshake; bus = {8000_0000, 0000_0013}.
- IDU holds `idu_allowin`=0 for 5 cycles during SEND → valid and bus held constant; WAIT_PC entered only the cycle after allowin=1.
- `arready` delayed 3 cycles, then `rvalid` delayed 4 cycles → `araddr` stable throughout; `perf_stall_cnt`=9 when `YSYX_23060208_IFU_PERF_EN` is defined, 0 otherwise.
- nextpc strobe 8000_0100 in WAIT_PC, then a stray strobe 8000_0200 during R → next `araddr`=8000_0100; stray strobe ignored.
- Fetch with `rresp`=2'b10 → instruction still delivered; `fetch_err` rises the cycle after `rvalid` and stays 1 across later OKAY fetches.
- `reset` pulled low while in R with `rvalid` pending → `rready` drops immediately; after release, refetch starts at 8000_0000 with `fetch_err`=0 and counters=0.

Source files
------------

// File: rtl/ysyx_23060208_ifu.sv
// ysyx_23060208_ifu - instruction fetch unit for the multi-cycle NPC core.
// Owns the PC and fetches one instruction at a time over an AXI4-Lite read
// port. Each instruction is handed to the IDU as {pc, inst}. The unit then
// waits for the EXU to return the next PC, so it never fetches speculatively.
// Optional feature macro: YSYX_23060208_IFU_PERF_EN enables the two
// performance counters. When it is undefined, both counter ports read as 0.
module ysyx_23060208_ifu #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(32'h8000_0000)
) (
    input  logic                      clock,
    input  logic                      reset,
    // AXI4-Lite read address channel
    output logic [DATA_WIDTH-1:0]     araddr,
    output logic                      arvalid,
    input  logic                      arready,
    // AXI4-Lite read data channel
    input  logic [DATA_WIDTH-1:0]     rdata,
    input  logic [1:0]                rresp,
    input  logic                      rvalid,
    output logic                      rready,
    // IFU -> IDU handshake
    output logic [2*DATA_WIDTH-1:0]   ifu_to_idu_bus,
    output logic                      ifu_to_idu_valid,
    input  logic                      idu_allowin,
    // next PC returned by the EXU
    input  logic [DATA_WIDTH-1:0]     exu_nextpc,
    input  logic                      exu_nextpc_valid,
    // status and performance
    output logic                      fetch_err,
    output logic [31:0]               perf_fetch_cnt,
    output logic [31:0]               perf_stall_cnt
);

    typedef enum logic [2:0] {
        BOOT    = 3'd0,
        AR      = 3'd1,
        R       = 3'd2,
        SEND    = 3'd3,
        WAIT_PC = 3'd4
    } state_t;

    state_t                  state_reg;
    logic [DATA_WIDTH-1:0]   pc_reg;
    logic [DATA_WIDTH-1:0]   inst_reg;
    logic                    fetch_err_reg;

    // Fetch FSM. It also holds the PC, the latched instruction and the sticky error flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= BOOT;
            pc_reg        <= RESET_PC;
            inst_reg      <= '0;
            fetch_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                BOOT: begin
                    state_reg <= AR;
                end
                AR: begin
                    if (arready) begin
                        state_reg <= R;
                    end
                end
                R: begin
                    if (rvalid) begin
                        inst_reg  <= rdata;
                        state_reg <= SEND;
                        // A faulted fetch is still delivered. Only the flag records it.
                        if (rresp != 2'b00) begin
                            fetch_err_reg <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (idu_allowin) begin
                        state_reg <= WAIT_PC;
                    end
                end
                WAIT_PC: begin
                    // The EXU strobe is honoured only here. Strobes in other states are dropped.
                    if (exu_nextpc_valid) begin
                        pc_reg    <= exu_nextpc;
                        state_reg <= AR;
                    end
                end
                default: begin
                    state_reg <= BOOT;
                end
            endcase
        end
    end

    // Handshake outputs are decoded from the state register alone. This keeps
    // them free of input-to-output paths and makes them drop as soon as reset asserts.
    assign arvalid          = (state_reg == AR);
    assign rready           = (state_reg == R);
    assign ifu_to_idu_valid = (state_reg == SEND);
    assign araddr           = pc_reg;
    assign ifu_to_idu_bus   = {pc_reg, inst_reg};
    assign fetch_err        = fetch_err_reg;

`ifdef YSYX_23060208_IFU_PERF_EN
    logic [31:0] fetch_cnt_reg;
    logic [31:0] stall_cnt_reg;

    // Performance counters. They count delivered instructions and cycles spent on the bus. Both wrap modulo 2^32.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_cnt_reg <= 32'd0;
            stall_cnt_reg <= 32'd0;
        end else begin
            if ((state_reg == SEND) && idu_allowin) begin
                fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
            end
            if ((state_reg == AR) || (state_reg == R)) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt_reg;
    assign perf_stall_cnt = stall_cnt_reg;
`else
    assign perf_fetch_cnt = 32'd0;
    assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_ysyx_23060208_ifu.sv
// Directed testbench for ysyx_23060208_ifu. Each scenario task drives the AXI
// and handshake inputs cycle by cycle and checks the outputs one cycle later.
module tb_ysyx_23060208_ifu;

`ifdef YSYX_23060208_IFU_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [63:0] ifu_to_idu_bus;
    logic        ifu_to_idu_valid;
    logic        idu_allowin;
    logic [31:0] exu_nextpc;
    logic        exu_nextpc_valid;
    logic        fetch_err;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;

    int checks = 0;
    int passes = 0;

    ysyx_23060208_ifu #(
        .DATA_WIDTH (32),
        .RESET_PC   (32'h8000_0000)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .araddr           (araddr),
        .arvalid          (arvalid),
        .arready          (arready),
        .rdata            (rdata),
        .rresp            (rresp),
        .rvalid           (rvalid),
        .rready           (rready),
        .ifu_to_idu_bus   (ifu_to_idu_bus),
        .ifu_to_idu_valid (ifu_to_idu_valid),
        .idu_allowin      (idu_allowin),
        .exu_nextpc       (exu_nextpc),
        .exu_nextpc_valid (exu_nextpc_valid),
        .fetch_err        (fetch_err),
        .perf_fetch_cnt   (perf_fetch_cnt),
        .perf_stall_cnt   (perf_stall_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one cycle. Outputs are then sampled and inputs driven 1 time unit after the edge.
    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        idu_allowin = 0; exu_nextpc = 0; exu_nextpc_valid = 0;
    endtask

    task automatic do_reset;
        reset = 0;
        clear_inputs();
        tick(); tick();
        reset = 1;
    endtask

    // Start in AR. Wait the given number of cycles for each channel, then complete the beat. Ends in SEND.
    task automatic run_fetch(input int ar_wait, input int r_wait,
                             input logic [31:0] data, input logic [1:0] resp);
        arready = 0;
        for (int i = 0; i < ar_wait; i++) tick();
        arready = 1;
        tick();
        arready = 0;
        for (int i = 0; i < r_wait; i++) tick();
        rvalid = 1; rdata = data; rresp = resp;
        tick();
        rvalid = 0; rdata = 0; rresp = 0;
    endtask

    // Start in SEND. The IDU accepts, then the EXU returns pc next cycle. Ends in AR.
    task automatic accept_and_next(input logic [31:0] pc);
        idu_allowin = 1;
        tick();
        idu_allowin = 0;
        exu_nextpc = pc; exu_nextpc_valid = 1;
        tick();
        exu_nextpc_valid = 0;
    endtask

    task automatic test_reset;
        do_reset();
        reset = 0;
        #1;
        checks++;
        if ({arvalid, rready, ifu_to_idu_valid, fetch_err} !== 4'b0000)
            $display("FAIL reset_hs: got %b expected 0000", {arvalid, rready, ifu_to_idu_valid, fetch_err});
        else passes++;
        checks++;
        if (ifu_to_idu_bus !== 64'h8000_0000_0000_0000)
            $display("FAIL reset_bus: got %h expected 8000000000000000", ifu_to_idu_bus);
        else passes++;
        checks++;
        if ({perf_fetch_cnt, perf_stall_cnt} !== 64'd0)
            $display("FAIL reset_perf: got %0d/%0d expected 0/0", perf_fetch_cnt, perf_stall_cnt);
        else passes++;
        tick();
        reset = 1;
        // BOOT still holds the handshake low, then AR follows.
        checks++;
        if (arvalid !== 1'b0) $display("FAIL boot_arvalid: got %b expected 0", arvalid);
        else passes++;
        tick();
        checks++;
        if (arvalid !== 1'b1 || araddr !== 32'h8000_0000)
            $display("FAIL first_ar: got arvalid=%b araddr=%h expected 1 80000000", arvalid, araddr);
        else passes++;
        $display("reset: first AR at %h", araddr);
    endtask

    task automatic test_basic_fetch;
        arready = 1;                 // handshake in cycle T
        tick();
        arready = 0;
        checks++;
        if (rready !== 1'b1 || arvalid !== 1'b0 || ifu_to_idu_valid !== 1'b0)
            $display("FAIL t1_state: got rready=%b arvalid=%b valid=%b expected 1 0 0", rready, arvalid, ifu_to_idu_valid);
        else passes++;
        rvalid = 1; rdata = 32'h0000_0013; rresp = 0;   // sampled in T+1
        tick();
        rvalid = 0; rdata = 0;
        checks++;
        if (ifu_to_idu_valid !== 1'b1 || rready !== 1'b0)
            $display("FAIL t2_valid: got valid=%b rready=%b expected 1 0", ifu_to_idu_valid, rready);
        else passes++;
        checks++;
        if (ifu_to_idu_bus !== 64'h8000_0000_0000_0013)
            $display("FAIL basic_bus: got %h expected 8000000000000013", ifu_to_idu_bus);
        else passes++;
        $display("basic fetch: bus=%h", ifu_to_idu_bus);
    endtask

    task automatic test_allowin_hold;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (ifu_to_idu_valid !== 1'b1 || ifu_to_idu_bus !== 64'h8000_0000_0000_0013)
                $display("FAIL hold_%0d: got valid=%b bus=%h expected 1 8000000000000013", i, ifu_to_idu_valid, ifu_to_idu_bus);
            else passes++;
            tick();
        end
        idu_allowin = 1;
        checks++;
        if (ifu_to_idu_valid !== 1'b1) $display("FAIL hold_last: got valid=%b expected 1", ifu_to_idu_valid);
        else passes++;
        tick();
        idu_allowin = 0;
        checks++;
        if (ifu_to_idu_valid !== 1'b0 || arvalid !== 1'b0 || rready !== 1'b0)
            $display("FAIL wait_pc_idle: got valid=%b arvalid=%b rready=%b expected 0 0 0", ifu_to_idu_valid, arvalid, rready);
        else passes++;
        checks++;
        if (perf_fetch_cnt !== (PERF ? 32'd1 : 32'd0) || perf_stall_cnt !== (PERF ? 32'd2 : 32'd0))
            $display("FAIL perf_basic: got %0d/%0d expected %0d/%0d", perf_fetch_cnt, perf_stall_cnt, PERF ? 1 : 0, PERF ? 2 : 0);
        else passes++;
        $display("allowin hold: accepted after 5 stall cycles");
    endtask

    task automatic test_stall;
        do_reset();
        tick();                       // BOOT -> AR
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (arvalid !== 1'b1 || araddr !== 32'h8000_0000)
                $display("FAIL ar_wait_%0d: got arvalid=%b araddr=%h expected 1 80000000", i, arvalid, araddr);
            else passes++;
            tick();
        end
        arready = 1;
        tick();
        arready = 0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rready !== 1'b1 || araddr !== 32'h8000_0000)
                $display("FAIL r_wait_%0d: got rready=%b araddr=%h expected 1 80000000", i, rready, araddr);
            else passes++;
            tick();
        end
        rvalid = 1; rdata = 32'h0010_0093; rresp = 0;
        tick();
        rvalid = 0; rdata = 0;
        checks++;
        if (perf_stall_cnt !== (PERF ? 32'd9 : 32'd0))
            $display("FAIL stall_cnt: got %0d expected %0d", perf_stall_cnt, PERF ? 9 : 0);
        else passes++;
        checks++;
        if (ifu_to_idu_bus !== 64'h8000_0000_0010_0093)
            $display("FAIL stall_bus: got %h expected 8000000000100093", ifu_to_idu_bus);
        else passes++;
        $display("stall: stall_cnt=%0d", perf_stall_cnt);
    endtask

    task automatic test_nextpc;
        accept_and_next(32'h8000_0100);
        checks++;
        if (arvalid !== 1'b1 || araddr !== 32'h8000_0100)
            $display("FAIL nextpc_ar: got arvalid=%b araddr=%h expected 1 80000100", arvalid, araddr);
        else passes++;
        arready = 1;
        tick();
        arready = 0;
        exu_nextpc = 32'h8000_0200; exu_nextpc_valid = 1;   // stray strobe in R
        tick();
        exu_nextpc_valid = 0;
        checks++;
        if (rready !== 1'b1 || araddr !== 32'h8000_0100)
            $display("FAIL stray_ignored: got rready=%b araddr=%h expected 1 80000100", rready, araddr);
        else passes++;
        rvalid = 1; rdata = 32'h0020_0113; rresp = 0;
        tick();
        rvalid = 0; rdata = 0;
        checks++;
        if (ifu_to_idu_bus !== 64'h8000_0100_0020_0113)
            $display("FAIL nextpc_bus: got %h expected 8000010000200113", ifu_to_idu_bus);
        else passes++;
        $display("nextpc: fetched pc=%h", ifu_to_idu_bus[63:32]);
    endtask

    task automatic test_fetch_err;
        accept_and_next(32'h8000_0104);
        arready = 1;
        tick();
        arready = 0;
        rvalid = 1; rdata = 32'hDEAD_BEEF; rresp = 2'b10;
        checks++;
        if (fetch_err !== 1'b0) $display("FAIL err_before: got %b expected 0", fetch_err);
        else passes++;
        tick();
        rvalid = 0; rdata = 0; rresp = 0;
        checks++;
        if (fetch_err !== 1'b1 || ifu_to_idu_valid !== 1'b1 || ifu_to_idu_bus !== 64'h8000_0104_DEAD_BEEF)
            $display("FAIL err_deliver: got err=%b valid=%b bus=%h expected 1 1 80000104deadbeef", fetch_err, ifu_to_idu_valid, ifu_to_idu_bus);
        else passes++;
        accept_and_next(32'h8000_0108);
        run_fetch(0, 0, 32'h0000_0013, 2'b00);
        checks++;
        if (fetch_err !== 1'b1 || ifu_to_idu_bus !== 64'h8000_0108_0000_0013)
            $display("FAIL err_sticky: got err=%b bus=%h expected 1 8000010800000013", fetch_err, ifu_to_idu_bus);
        else passes++;
        $display("fetch_err: err=%b after OKAY fetch", fetch_err);
    endtask

    task automatic test_back_to_back;
        idu_allowin = 1;              // accept in S
        tick();
        idu_allowin = 0;
        exu_nextpc = 32'h8000_010C; exu_nextpc_valid = 1;
        checks++;
        if (ifu_to_idu_valid !== 1'b0 || arvalid !== 1'b0)
            $display("FAIL b2b_s1: got valid=%b arvalid=%b expected 0 0", ifu_to_idu_valid, arvalid);
        else passes++;
        checks++;
        if (perf_fetch_cnt !== (PERF ? 32'd4 : 32'd0))
            $display("FAIL b2b_fetch_cnt: got %0d expected %0d", perf_fetch_cnt, PERF ? 4 : 0);
        else passes++;
        tick();                       // S+2: AR
        exu_nextpc_valid = 0;
        arready = 1;
        checks++;
        if (arvalid !== 1'b1 || araddr !== 32'h8000_010C)
            $display("FAIL b2b_s2: got arvalid=%b araddr=%h expected 1 8000010c", arvalid, araddr);
        else passes++;
        tick();
        arready = 0;
        rvalid = 1; rdata = 32'h0030_0193; rresp = 0;
        tick();                       // S+4: next SEND
        rvalid = 0; rdata = 0;
        checks++;
        if (ifu_to_idu_valid !== 1'b1 || ifu_to_idu_bus !== 64'h8000_010C_0030_0193)
            $display("FAIL b2b_s4: got valid=%b bus=%h expected 1 8000010c00300193", ifu_to_idu_valid, ifu_to_idu_bus);
        else passes++;
        checks++;
        if (perf_stall_cnt !== (PERF ? 32'd18 : 32'd0))
            $display("FAIL b2b_stall_cnt: got %0d expected %0d", perf_stall_cnt, PERF ? 18 : 0);
        else passes++;
        $display("back_to_back: next instruction valid 4 cycles after accept");
    endtask

    task automatic test_reset_mid;
        accept_and_next(32'h8000_0110);
        arready = 1;
        tick();
        arready = 0;
        rvalid = 1; rdata = 32'h1111_1111;
        checks++;
        if (rready !== 1'b1) $display("FAIL mid_in_r: got rready=%b expected 1", rready);
        else passes++;
        reset = 0;
        #1;
        checks++;
        if (rready !== 1'b0 || arvalid !== 1'b0 || fetch_err !== 1'b0)
            $display("FAIL mid_async: got rready=%b arvalid=%b err=%b expected 0 0 0", rready, arvalid, fetch_err);
        else passes++;
        clear_inputs();
        tick();
        reset = 1;
        tick();
        checks++;
        if (arvalid !== 1'b1 || araddr !== 32'h8000_0000 || fetch_err !== 1'b0)
            $display("FAIL mid_refetch: got arvalid=%b araddr=%h err=%b expected 1 80000000 0", arvalid, araddr, fetch_err);
        else passes++;
        checks++;
        if (perf_fetch_cnt !== 32'd0 || perf_stall_cnt !== 32'd0)
            $display("FAIL mid_perf: got %0d/%0d expected 0/0", perf_fetch_cnt, perf_stall_cnt);
        else passes++;
        $display("reset_mid: refetch from %h", araddr);
    endtask

    initial begin
        reset = 0;
        clear_inputs();
        test_reset();
        test_basic_fetch();
        test_allowin_hold();
        test_stall();
        test_nextpc();
        test_fetch_err();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
